// File: rtl/pe_loop_sequencer_pkg.sv
// Shared types and constants for the PE loop sequencer: loop configuration,
// FSM states and the configuration legality check.
package pe_loop_sequencer_pkg;

  localparam int PAD_ADDR_WD = 8;
  localparam int LOOP_CNT_WD = 4;
  localparam int IW_WD       = 5;
  localparam int NUM_LOOPS   = 3;

  // Loop nest positions, innermost first
  localparam int LOOP_S  = 0;
  localparam int LOOP_CH = 1;
  localparam int LOOP_OW = 2;

  typedef struct packed {
    logic [LOOP_CNT_WD-1:0] s;
    logic [LOOP_CNT_WD-1:0] ow;
    logic [LOOP_CNT_WD-1:0] ch;
  } pe_loop_conf_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } seq_state_t;

  // Input row width seen by one output row: OW + S - 1
  function automatic logic [IW_WD-1:0] iw_of(input pe_loop_conf_t c);
    return {1'b0, c.ow} + {1'b0, c.s} - 5'd1;
  endfunction

  // The only runtime multiply: guarantees every input-pad address fits in 8 bits
  function automatic logic conf_invalid(input pe_loop_conf_t c);
    logic [8:0] prod;
    prod = {5'b0, c.ch} * {4'b0, iw_of(c)};
    return (c.s == '0) || (c.ow == '0) || (c.ch == '0) || (prod > 9'd256);
  endfunction

endpackage

// File: rtl/pe_loop_sequencer_if.sv
// Control/beat bundle between a PE controller (master) and the loop sequencer (slave).
interface pe_loop_sequencer_if;
  import pe_loop_sequencer_pkg::*;

  logic                   i_start;
  logic                   i_abort;
  pe_loop_conf_t          i_conf;
  logic                   i_ready;
  logic                   o_valid;
  logic [PAD_ADDR_WD-1:0] o_ipaddr;
  logic [PAD_ADDR_WD-1:0] o_wpaddr;
  logic [LOOP_CNT_WD-1:0] o_ppaddr;
  logic                   o_psum_init;
  logic                   o_psum_last;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_error;

  modport master (
    output i_start, i_abort, i_conf, i_ready,
    input  o_valid, o_ipaddr, o_wpaddr, o_ppaddr, o_psum_init, o_psum_last,
           o_busy, o_done, o_error
  );

  modport slave (
    input  i_start, i_abort, i_conf, i_ready,
    output o_valid, o_ipaddr, o_wpaddr, o_ppaddr, o_psum_init, o_psum_last,
           o_busy, o_done, o_error
  );

endinterface

// File: rtl/pe_loop_counter.sv
// One loop level: counts 0..max_val on enable, wrap flags the step from max back to 0.
module pe_loop_counter
  import pe_loop_sequencer_pkg::*;
#(
  parameter int WD = LOOP_CNT_WD
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          clr,
  input  logic          en,
  input  logic [WD-1:0] max_val,
  output logic [WD-1:0] count,
  output logic          at_max,
  output logic          wrap
);

  logic [WD-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= at_max ? '0 : count_reg + WD'(1);
    end
  end

  assign count  = count_reg;
  assign at_max = (count_reg == max_val);
  assign wrap   = en && at_max;

endmodule

// File: rtl/pe_loop_sequencer.sv
// Walks the s/ch/ow loop nest of one PE pass and emits registered pad addresses
// as a valid/ready beat stream.
module pe_loop_sequencer
  import pe_loop_sequencer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  pe_loop_sequencer_if.slave bus
);

  seq_state_t             state_reg, state_next;
  pe_loop_conf_t          conf_reg;
  logic                   start_ok;
  logic                   handshake;
  logic                   cnt_clr;
  logic                   s_wrap, ch_wrap, ow_wrap;
  logic [LOOP_CNT_WD-1:0] s_idx, ch_idx, ow_idx;
  logic                   s_at_max, ch_at_max;
  logic [NUM_LOOPS-1:0][LOOP_CNT_WD-1:0] cnt_max;
  logic [PAD_ADDR_WD-1:0] ip_reg, ip_row_reg, wp_reg;
  logic [PAD_ADDR_WD-1:0] iw_ext, ow_next_ext;

  assign handshake = (state_reg == ST_RUN) && bus.i_ready;
  assign cnt_clr   = (state_reg == ST_CHECK);
  assign start_ok  = bus.i_start && !bus.i_abort &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_ERR));

  assign cnt_max[LOOP_S]  = conf_reg.s  - 4'd1;
  assign cnt_max[LOOP_CH] = conf_reg.ch - 4'd1;
  assign cnt_max[LOOP_OW] = conf_reg.ow - 4'd1;

  // Each level steps when the level inside it wraps
  for (genvar gi = 0; gi < NUM_LOOPS; gi++) begin : g_loop
    logic                   en;
    logic                   at_max;
    logic                   wrap;
    logic [LOOP_CNT_WD-1:0] count;

    if (gi == 0) begin : g_first
      assign en = handshake;
    end else begin : g_chain
      assign en = g_loop[gi-1].wrap;
    end

    pe_loop_counter #(.WD(LOOP_CNT_WD)) u_cnt (
      .clk     (i_clk),
      .srst    (i_rst),
      .clr     (cnt_clr),
      .en      (en),
      .max_val (cnt_max[gi]),
      .count   (count),
      .at_max  (at_max),
      .wrap    (wrap)
    );
  end

  assign s_idx     = g_loop[LOOP_S].count;
  assign ch_idx    = g_loop[LOOP_CH].count;
  assign ow_idx    = g_loop[LOOP_OW].count;
  assign s_at_max  = g_loop[LOOP_S].at_max;
  assign ch_at_max = g_loop[LOOP_CH].at_max;
  assign s_wrap    = g_loop[LOOP_S].wrap;
  assign ch_wrap   = g_loop[LOOP_CH].wrap;
  assign ow_wrap   = g_loop[LOOP_OW].wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      conf_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        conf_reg <= bus.i_conf;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.i_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ERR: if (bus.i_start) state_next = ST_CHECK;
        ST_CHECK:        state_next = conf_invalid(conf_reg) ? ST_ERR : ST_RUN;
        ST_RUN:          if (ow_wrap) state_next = ST_DONE;
        ST_DONE:         state_next = ST_IDLE;
        default:         state_next = ST_IDLE;
      endcase
    end
  end

  assign iw_ext      = {3'b0, iw_of(conf_reg)};
  assign ow_next_ext = {4'b0, ow_idx} + 8'd1;

  // ip_row_reg = ch_idx*IW + ow_idx, i.e. the input address at s_idx = 0.
  // wp is contiguous across the s->ch wrap, so it only resets on an ow step.
  always_ff @(posedge i_clk) begin
    if (i_rst || cnt_clr) begin
      ip_reg     <= '0;
      ip_row_reg <= '0;
      wp_reg     <= '0;
    end else if (handshake) begin
      if (!s_wrap) begin
        ip_reg <= ip_reg + 8'd1;
        wp_reg <= wp_reg + 8'd1;
      end else if (!ch_wrap) begin
        ip_row_reg <= ip_row_reg + iw_ext;
        ip_reg     <= ip_row_reg + iw_ext;
        wp_reg     <= wp_reg + 8'd1;
      end else if (!ow_wrap) begin
        ip_row_reg <= ow_next_ext;
        ip_reg     <= ow_next_ext;
        wp_reg     <= '0;
      end
    end
  end

  assign bus.o_valid     = (state_reg == ST_RUN);
  assign bus.o_busy      = (state_reg == ST_CHECK) || (state_reg == ST_RUN);
  assign bus.o_done      = (state_reg == ST_DONE);
  assign bus.o_error     = (state_reg == ST_ERR);
  assign bus.o_ipaddr    = ip_reg;
  assign bus.o_wpaddr    = wp_reg;
  assign bus.o_ppaddr    = ow_idx;
  assign bus.o_psum_init = bus.o_valid && (s_idx == '0) && (ch_idx == '0);
  assign bus.o_psum_last = bus.o_valid && s_at_max && ch_at_max;

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Directed bench for pe_loop_sequencer: address sequences, stalls, error
// configurations, abort and reset, against hand-computed vectors.
module tb_pe_loop_sequencer;
  import pe_loop_sequencer_pkg::*;

  typedef struct packed {
    logic [7:0] ip;
    logic [7:0] wp;
    logic [3:0] pp;
    logic       init;
    logic       last;
  } beat_t;

  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;

  beat_t beats[$];
  int    done_cnt;
  int    done_cyc;
  int    first_valid_cyc;
  int    stall_bad;
  int    flag_bad;

  pe_loop_sequencer_if bus();

  pe_loop_sequencer dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic pe_loop_conf_t mk_conf(input int s, input int ow, input int ch);
    pe_loop_conf_t c;
    c.s  = 4'(s);
    c.ow = 4'(ow);
    c.ch = 4'(ch);
    return c;
  endfunction

  // Starts one pass and records every handshake for a fixed number of cycles.
  // cyc 0 is the CHECK cycle; i_conf is scrambled after the start edge.
  task automatic run_pass(input pe_loop_conf_t conf, input bit toggle_ready,
                          input bit noisy, input int cycles);
    beat_t cur;
    beat_t held;
    bit    held_v;
    beats.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    stall_bad = 0; flag_bad = 0; held_v = 1'b0; held = '0;
    @(posedge i_clk); #1;
    bus.i_start = 1'b1; bus.i_conf = conf; bus.i_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0; bus.i_conf = '0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      bus.i_ready = toggle_ready ? cyc[0] : 1'b1;
      if (noisy) begin
        bus.i_start = (cyc >= 1 && cyc <= 4);
        bus.i_conf  = 12'hFFF;
      end
      @(negedge i_clk);
      cur = '{bus.o_ipaddr, bus.o_wpaddr, bus.o_ppaddr, bus.o_psum_init, bus.o_psum_last};
      if (held_v && cur !== held) stall_bad++;
      held_v = bus.o_valid && !bus.i_ready;
      held   = cur;
      if (bus.o_valid && bus.i_ready) beats.push_back(cur);
      if (bus.o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!bus.o_valid && (bus.o_psum_init || bus.o_psum_last)) flag_bad++;
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(posedge i_clk); #1;
    end
    bus.i_start = 1'b0; bus.i_ready = 1'b1; bus.i_conf = '0;
    $display("pass s=%0d ow=%0d ch=%0d toggle=%0d beats=%0d done_cnt=%0d done_cyc=%0d",
             conf.s, conf.ow, conf.ch, toggle_ready, beats.size(), done_cnt, done_cyc);
  endtask

  task automatic test_reset();
    logic [25:0] outs;
    i_rst = 1'b1; bus.i_start = 1'b1; bus.i_conf = mk_conf(3, 2, 1);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    outs = {bus.o_valid, bus.o_ipaddr, bus.o_wpaddr, bus.o_ppaddr, bus.o_psum_init,
            bus.o_psum_last, bus.o_busy, bus.o_done, bus.o_error};
    checks++;
    if (outs !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0; bus.i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b valid=%b exp=0/0", bus.o_busy, bus.o_valid);
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    int         exp_ip[6] = '{0, 1, 2, 1, 2, 3};
    int         exp_wp[6] = '{0, 1, 2, 0, 1, 2};
    int         exp_pp[6] = '{0, 0, 0, 1, 1, 1};
    logic [5:0] exp_init  = 6'b001001;
    logic [5:0] exp_last  = 6'b100100;
    run_pass(mk_conf(3, 2, 1), 1'b0, 1'b0, 12);
    checks++;
    if (beats.size() != 6) begin
      errors++; $display("FAIL basic_count got=%0d exp=6", beats.size());
    end
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].ip !== exp_ip[i][7:0] || beats[i].wp !== exp_wp[i][7:0] ||
          beats[i].pp !== exp_pp[i][3:0] || beats[i].init !== exp_init[i] ||
          beats[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got ip=%0d wp=%0d pp=%0d init=%b last=%b exp ip=%0d wp=%0d pp=%0d init=%b last=%b",
                 i, beats[i].ip, beats[i].wp, beats[i].pp, beats[i].init, beats[i].last,
                 exp_ip[i], exp_wp[i], exp_pp[i], exp_init[i], exp_last[i]);
      end
    end
    checks++;
    if (first_valid_cyc != 1) begin
      errors++; $display("FAIL basic_latency got=%0d exp=1", first_valid_cyc);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 7) begin
      errors++; $display("FAIL basic_done got cnt=%0d cyc=%0d exp cnt=1 cyc=7", done_cnt, done_cyc);
    end
    checks++;
    if (flag_bad != 0) begin
      errors++; $display("FAIL basic_flags_idle got=%0d exp=0", flag_bad);
    end
  endtask

  task automatic test_ch2();
    int         exp_ip[4] = '{0, 1, 2, 3};
    logic [3:0] exp_init  = 4'b0001;
    logic [3:0] exp_last  = 4'b1000;
    run_pass(mk_conf(2, 1, 2), 1'b0, 1'b0, 10);
    checks++;
    if (beats.size() != 4) begin
      errors++; $display("FAIL ch2_count got=%0d exp=4", beats.size());
    end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].ip !== exp_ip[i][7:0] || beats[i].wp !== exp_ip[i][7:0] ||
          beats[i].pp !== 4'd0 || beats[i].init !== exp_init[i] ||
          beats[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL ch2_beat%0d got ip=%0d wp=%0d pp=%0d init=%b last=%b exp ip=%0d wp=%0d pp=0 init=%b last=%b",
                 i, beats[i].ip, beats[i].wp, beats[i].pp, beats[i].init, beats[i].last,
                 exp_ip[i], exp_ip[i], exp_init[i], exp_last[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 5) begin
      errors++; $display("FAIL ch2_done got cnt=%0d cyc=%0d exp cnt=1 cyc=5", done_cnt, done_cyc);
    end
  endtask

  task automatic test_stall();
    int exp_ip[6] = '{0, 1, 2, 1, 2, 3};
    int exp_wp[6] = '{0, 1, 2, 0, 1, 2};
    run_pass(mk_conf(3, 2, 1), 1'b1, 1'b0, 18);
    checks++;
    if (beats.size() != 6) begin
      errors++; $display("FAIL stall_count got=%0d exp=6", beats.size());
    end
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].ip !== exp_ip[i][7:0] || beats[i].wp !== exp_wp[i][7:0]) begin
        errors++;
        $display("FAIL stall_beat%0d got ip=%0d wp=%0d exp ip=%0d wp=%0d",
                 i, beats[i].ip, beats[i].wp, exp_ip[i], exp_wp[i]);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL stall_hold got=%0d unstable exp=0", stall_bad);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 12) begin
      errors++; $display("FAIL stall_done got cnt=%0d cyc=%0d exp cnt=1 cyc=12", done_cnt, done_cyc);
    end
  endtask

  // Start pulses and conf garbage during RUN must not disturb the pass;
  // a second pass follows straight after.
  task automatic test_back_to_back();
    int exp_ip[6] = '{0, 1, 2, 1, 2, 3};
    run_pass(mk_conf(3, 2, 1), 1'b0, 1'b1, 12);
    checks++;
    if (beats.size() != 6 || done_cnt != 1 || done_cyc != 7) begin
      errors++;
      $display("FAIL ignore_start got beats=%0d done=%0d cyc=%0d exp 6/1/7", beats.size(), done_cnt, done_cyc);
    end
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].ip !== exp_ip[i][7:0]) begin
        errors++; $display("FAIL ignore_start_ip%0d got=%0d exp=%0d", i, beats[i].ip, exp_ip[i]);
      end
    end
    run_pass(mk_conf(2, 1, 2), 1'b0, 1'b0, 10);
    checks++;
    if (beats.size() != 4 || done_cnt != 1) begin
      errors++; $display("FAIL b2b_second got beats=%0d done=%0d exp 4/1", beats.size(), done_cnt);
    end
  endtask

  task automatic test_errors();
    @(posedge i_clk); #1;
    bus.i_start = 1'b1; bus.i_conf = mk_conf(0, 2, 1);
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_error !== 1'b0) begin
      errors++; $display("FAIL err_check_cycle busy=%b error=%b exp 1/0", bus.o_busy, bus.o_error);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      @(negedge i_clk);
      checks++;
      if (bus.o_error !== 1'b1 || bus.o_valid !== 1'b0) begin
        errors++; $display("FAIL err_s0_c%0d error=%b valid=%b exp 1/0", i, bus.o_error, bus.o_valid);
      end
    end
    // Restart from ERR with ch*IW = 15*29 = 435
    @(posedge i_clk); #1;
    bus.i_start = 1'b1; bus.i_conf = mk_conf(15, 15, 15);
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL err_restart_clear error=%b busy=%b exp 0/1", bus.o_error, bus.o_busy);
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++;
    if (bus.o_error !== 1'b1) begin
      errors++; $display("FAIL err_big got error=%b exp=1", bus.o_error);
    end
    // ch*IW = 15*18 = 270, just over the limit
    @(posedge i_clk); #1;
    bus.i_start = 1'b1; bus.i_conf = mk_conf(9, 10, 15);
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++;
    if (bus.o_error !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL err_270 error=%b valid=%b exp 1/0", bus.o_error, bus.o_valid);
    end
    $display("error configurations applied");
    run_pass(mk_conf(3, 2, 1), 1'b0, 1'b0, 12);
    checks++;
    if (beats.size() != 6 || done_cnt != 1 || bus.o_error !== 1'b0) begin
      errors++;
      $display("FAIL err_recover got beats=%0d done=%0d error=%b exp 6/1/0", beats.size(), done_cnt, bus.o_error);
    end
  endtask

  // ch*IW = 15*17 = 255: largest legal footprint, last ip 14*17+8+8 = 254
  task automatic test_boundary();
    run_pass(mk_conf(9, 9, 15), 1'b0, 1'b0, 1225);
    checks++;
    if (beats.size() != 1215 || done_cnt != 1 || done_cyc != 1216) begin
      errors++;
      $display("FAIL bound_count got beats=%0d done=%0d cyc=%0d exp 1215/1/1216", beats.size(), done_cnt, done_cyc);
    end
    if (beats.size() > 0) begin
      checks++;
      if (beats[beats.size()-1] !== '{8'd254, 8'd134, 4'd8, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bound_last got ip=%0d wp=%0d pp=%0d init=%b last=%b exp 254/134/8/0/1",
                 beats[beats.size()-1].ip, beats[beats.size()-1].wp, beats[beats.size()-1].pp,
                 beats[beats.size()-1].init, beats[beats.size()-1].last);
      end
    end
  endtask

  task automatic test_abort();
    int seen_done;
    seen_done = 0;
    @(posedge i_clk); #1;
    bus.i_start = 1'b1; bus.i_conf = mk_conf(3, 2, 1); bus.i_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    bus.i_abort = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_ipaddr !== 8'd2) begin
      errors++; $display("FAIL abort_beat3 valid=%b ip=%0d exp 1/2", bus.o_valid, bus.o_ipaddr);
    end
    @(posedge i_clk); #1;
    bus.i_abort = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle valid=%b busy=%b done=%b exp 0/0/0", bus.o_valid, bus.o_busy, bus.o_done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      if (bus.o_done || bus.o_valid) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL abort_quiet got=%0d active cycles exp=0", seen_done);
    end
    $display("abort at beat 3 applied");
    run_pass(mk_conf(3, 2, 1), 1'b0, 1'b0, 12);
    checks++;
    if (beats.size() != 6 || (beats.size() > 0 && beats[0].ip !== 8'd0)) begin
      errors++; $display("FAIL abort_replay got beats=%0d exp 6 starting at ip 0", beats.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] outs;
    int          active;
    active = 0;
    @(posedge i_clk); #1;
    bus.i_start = 1'b1; bus.i_conf = mk_conf(3, 2, 1);
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    outs = {bus.o_valid, bus.o_ipaddr, bus.o_wpaddr, bus.o_ppaddr, bus.o_psum_init,
            bus.o_psum_last, bus.o_busy, bus.o_done, bus.o_error};
    checks++;
    if (outs !== 26'd0) begin
      errors++; $display("FAIL rst_mid_outputs got=%h exp=0", outs);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (bus.o_valid || bus.o_busy || bus.o_done) active++;
    end
    checks++;
    if (active != 0) begin
      errors++; $display("FAIL rst_mid_resume got=%0d active cycles exp=0", active);
    end
    $display("reset mid-pass applied");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_conf  = '0;
    bus.i_ready = 1'b1;
    test_reset();
    test_basic();
    test_ch2();
    test_stall();
    test_back_to_back();
    test_errors();
    test_boundary();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_loop_sequencer.md
PE_LOOP_SEQUENCER -- requirements
Module: pe_loop_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset; both ports are listed first below.
REQ-002 i_clk  input  1  clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous, active-high.
REQ-004 i_start  input  1  pulse; requests one pass; accepted only in IDLE or ERR.
REQ-005 i_abort  input  1  terminates any pass; highest priority after reset.
REQ-006 i_conf  input  12  packed PeLoopConf: s [3:0] filter taps, ow [3:0] output width, ch [3:0] channels.
REQ-007 o_valid  output  1  beat available.
REQ-008 i_ready  input  1  datapath accepts beat; handshake = o_valid & i_ready.
REQ-009 o_ipaddr  output  8  input-pad read address.
REQ-010 o_wpaddr  output  8  weight-pad read address.
REQ-011 o_ppaddr  output  4  psum-pad address (= ow index).
REQ-012 o_psum_init  output  1  first beat of an output pixel (ch=0, s=0).
REQ-013 o_psum_last  output  1  last beat of an output pixel (ch=CH-1, s=S-1).
REQ-014 o_busy  output  1  high in CHECK and RUN.
REQ-015 o_done  output  1  one-cycle pulse at pass completion.
REQ-016 o_error  output  1  high while in ERR.

Function
REQ-017 States SHALL be IDLE, CHECK, RUN, DONE, ERR.
REQ-018 IDLE + i_start -> CHECK; i_conf latched on that edge; later i_conf changes ignored until next accepted start.
REQ-019 CHECK lasts one cycle: IW = ow+s-1 (5 bits); error if s=0, ow=0, ch=0 or ch*IW > 256 (9-bit product); error -> ERR, else -> RUN with all counters 0.
REQ-020 Loop nest, innermost first: s_idx 0..S-1, ch_idx 0..CH-1, ow_idx 0..OW-1; indices advance only on handshake.
REQ-021 o_ipaddr = ch_idx*IW + ow_idx + s_idx; o_wpaddr = ch_idx*S + s_idx; o_ppaddr = ow_idx; all registered, never exceed 255 after CHECK passes.
REQ-022 First beat: o_valid high the cycle after CHECK (start-to-first-beat latency 2 cycles).
REQ-023 In RUN o_valid SHALL stay high; with i_ready low all beat outputs SHALL hold stable.
REQ-024 Handshake on final beat (all indices at max) -> DONE; o_valid low in DONE; o_done=1 for exactly that cycle; DONE -> IDLE.
REQ-025 Total handshakes per pass SHALL equal OW*CH*S exactly.
REQ-026 ERR holds o_error=1 until i_start (re-enters CHECK, error cleared) or i_abort (-> IDLE).
REQ-027 i_abort in any state -> IDLE next cycle; no o_done; o_valid low next cycle.
REQ-028 i_start in CHECK, RUN or DONE SHALL be ignored; i_start with i_abort same cycle: abort wins.
REQ-029 o_psum_init / o_psum_last valid only when o_valid=1, otherwise 0; for CH=1,S=1 both high on every beat.

Reset
REQ-030 On i_rst: state IDLE, all counters and latched config 0; o_valid, o_busy, o_done, o_error, o_psum_init, o_psum_last, all address outputs 0.
REQ-031 Reset mid-pass SHALL abandon the pass with no o_done; first cycle after reset deassert is IDLE.

Structure
REQ-032 PeLoopConf struct, state enum, PadAddrWd=8, LoopCntWd=4 SHALL live in the shared PE config package.
REQ-033 One sub-module pe_loop_counter (counter with max compare, enable, wrap flag) SHALL be instantiated three times and chained by wrap flags.
REQ-034 Address math SHALL use incremental adders (base registers advanced on wrap), no runtime multipliers except the single CHECK-stage product.

Verification
REQ-035 s=3,ow=2,ch=1, i_ready=1 -> ip 0,1,2,1,2,3; wp 0,1,2,0,1,2; pp 0,0,0,1,1,1; init beats 1,4; last beats 3,6; o_done one cycle after beat 6.
REQ-036 s=2,ow=1,ch=2 -> ip 0,1,2,3; wp 0,1,2,3; pp 0; init beat 1 only; last beat 4 only.
REQ-037 REQ-035 config with i_ready toggling 1010... -> identical address sequence, outputs stable in stall cycles, 6 handshakes total.
REQ-038 s=0 -> o_error=1 two cycles after start, no o_valid; s=15,ow=15,ch=15 (ch*IW=435) -> ERR; then valid start clears o_error.
REQ-039 i_abort at beat 3 of REQ-035 -> o_valid low next cycle, IDLE, no o_done; new start replays from ip 0.
REQ-040 i_rst asserted mid-RUN -> all outputs 0 next cycle; pass not resumed.
